mlp_layer_engine: RTL and testbench
===================================

# mlp_layer_engine

Parametrised fully-connected layer engine for the MNIST accelerator. It streams `N_IN` signed activations in over a valid/ready handshake and fetches one row of `N_OUT` weights per activation from a synchronous weight memory. All `N_OUT` lanes accumulate in parallel with saturation. Results then drain one neuron per handshake, with optional ReLU, and an argmax index is produced per frame. One instance serves as hidden layer (784→32) or output layer (32→10), and two instances chain directly.

## Interface
- `N_IN`, 784, activations per frame
- `N_OUT`, 32, neurons (parallel MAC lanes), ≥2
- `DATA_W`, 32, signed activation/result width
- `W_W`, 16, signed weight width
- `ACC_W`, 32, signed accumulator width, ≥ `DATA_W`
- `clk` in 1, sole clock, rising edge
- `reset` in 1, asynchronous, active-high
- `in_valid` in 1, activation beat valid
- `in_ready` out 1, engine accepts beat
- `in_data` in `DATA_W`, signed activation
- `wt_addr` out `$clog2(N_IN)`, weight row address
- `wt_data` in `N_OUT*W_W`, row returned one cycle after `wt_addr`; lane j in bits [j*W_W +: W_W]
- `out_valid` out 1, result beat valid
- `out_ready` in 1, consumer accepts result
- `out_data` out `DATA_W`, neuron result
- `out_idx` out `$clog2(N_OUT)`, neuron index of `out_data`
- `out_last` out 1, marks `out_idx == N_OUT-1`
- `done` out 1, one-cycle pulse after the last result handshake
- `argmax` out `$clog2(N_OUT)`, index of the largest result of the last frame

## Operation
- States: IDLE, ACC, FLUSH, DRAIN.
- IDLE: `in_ready`=1. The first accepted beat (k=0) moves to ACC. It flags the MAC stage to load rather than add, so there is no separate clear cycle.
- `wt_addr` = accepted-beat count `k`, driven combinationally. The beat is accepted on `in_valid & in_ready`.
- Accepted beat is registered (`act_q`, `vld_q`, `first_q`). The next cycle, lane j computes `acc[j] = sat(first_q ? p : acc[j] + p)`, where p = `act_q * wt_data[j]` at full width `DATA_W+W_W`. Cycles with `vld_q`=0 leave `acc` unchanged.
- `sat()` clamps to the signed `ACC_W` range. This applies to both the product and the sum.
- ACC: `in_ready`=1 until beat `N_IN-1` is accepted, then ACC→FLUSH with `in_ready`=0.
- FLUSH: one cycle, completes the final MAC, then FLUSH→DRAIN.
- DRAIN: `out_valid`=1. `out_data` is `acc[idx]` clamped to `DATA_W` bits, with ReLU per Configuration. `out_idx` = idx.
  - idx advances on `out_valid & out_ready`.
  - On the `out_last` handshake: go to IDLE, pulse `done`, update `argmax`.
- Argmax: a running max is tracked over the post-ReLU results as they are handshaked. On ties, the lowest index wins. `argmax` holds until the next frame's `done`.
- `in_ready`=0 in FLUSH and DRAIN. Beats offered there are not accepted.
- Reset mid-frame: the partial frame is discarded, with no `done` pulse. The next accepted beat starts a fresh frame.

## Timing
- Reset values:
  - state IDLE
  - `in_ready`=1
  - `out_valid`=0, `out_last`=0, `done`=0
  - `out_data`=0, `out_idx`=0
  - `argmax`=0
  - `wt_addr`=0
  - accumulators 0
- Throughput: one activation per cycle at full `in_valid`.
- Frame latency: last input accepted at cycle t; MAC at t+1 (FLUSH); `out_valid` with idx 0 at t+2.
- Drain: `N_OUT` cycles at full `out_ready`; `done` in the cycle after the last handshake.
- Input→next frame: a new frame's first beat can be accepted in the cycle `done` is high.
- Stalls:
  - `in_valid` gaps: `wt_addr` holds and `vld_q`=0.
  - `out_ready` low: `out_data`, `out_idx` and `out_last` are held stable.

## Configuration
- `MLP_RELU_EN` defined: `out_data` = max(0, result), and argmax is computed on the rectified values.
- `MLP_RELU_EN` undefined: `out_data` = signed saturated result, and argmax is computed on the signed values.
- Defining the macro is the hidden-layer build; leaving it undefined is the output-layer build.

## Test plan
All scenarios use `N_IN`=4, `N_OUT`=3, `W_W`=8, `DATA_W`=`ACC_W`=16 unless noted.
- Basic frame: inputs 1,2,3,4; lane weights w0=1, w1=-1, w2=2 for all rows.
  - ReLU off → out 10, -10, 20; `argmax`=2; `done` 1 cycle after the idx-2 handshake.
  - ReLU on → 10, 0, 20.
- Back-pressure:
  - `in_valid` toggling 1010 → same results.
  - `out_ready` low for 3 cycles at idx 1 → `out_data`=-10 held, no skipped index.
- Saturation: inputs 32767 ×4, all weights 127 → every result = 32767 with no wrap. The same frame with weights -128 → -32768.
- Argmax tie: results 5, 5, 3 → `argmax`=0.
- Back-to-back: second frame's first beat offered during `done`.
  - Accepted that cycle.
  - Accumulators loaded fresh, with no carry-over of first-frame sums.
- Reset mid-frame: assert `reset` after beat 2.
  - All outputs return to reset values asynchronously.
  - A following 4-beat frame yields correct results, with no `done` from the aborted frame.

Source files
------------

// File: rtl/mlp_layer_engine.sv
// Fully-connected layer engine: streams activations, runs N_OUT saturating MAC lanes, then drains results with argmax.
// Optional ReLU on the drained results is enabled by defining MLP_RELU_EN (hidden-layer build).
module mlp_layer_engine #(
    parameter int N_IN   = 784,
    parameter int N_OUT  = 32,
    parameter int DATA_W = 32,
    parameter int W_W    = 16,
    parameter int ACC_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic [$clog2(N_IN)-1:0]    wt_addr,
    input  logic [N_OUT*W_W-1:0]       wt_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(N_OUT)-1:0]   out_idx,
    output logic                       out_last,
    output logic                       done,
    output logic [$clog2(N_OUT)-1:0]   argmax
);
    localparam int AW = $clog2(N_IN);
    localparam int IW = $clog2(N_OUT);
    localparam int PW = DATA_W + W_W;
    localparam int SW = ((PW > ACC_W) ? PW : ACC_W) + 1;
    localparam logic [AW-1:0] K_LAST   = AW'(N_IN - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_OUT - 1);
    localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] DAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] DAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, FLUSH, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             k_q, k_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic signed [DATA_W-1:0]  act_q, act_d;
    logic                      vld_q, vld_d, first_q, first_d;
    logic signed [ACC_W-1:0]   acc_q [N_OUT];
    logic signed [ACC_W-1:0]   acc_d [N_OUT];
    logic signed [DATA_W-1:0]  best_q, best_d;
    logic [IW-1:0]             best_idx_q, best_idx_d, argmax_q, argmax_d;
    logic                      done_q, done_d;

    logic                      accept, out_hs, upd;
    logic [IW-1:0]             cand_idx;
    logic signed [DATA_W-1:0]  result;
    logic signed [W_W-1:0]     w_lane;
    logic signed [PW-1:0]      a_ext, w_ext, prod;
    logic signed [ACC_W-1:0]   psat;
    logic signed [SW-1:0]      sum;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SW-1:0] v);
        if (v > ACC_MAX) return ACC_MAX[ACC_W-1:0];
        if (v < ACC_MIN) return ACC_MIN[ACC_W-1:0];
        return v[ACC_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
        if (v > DAT_MAX) return DAT_MAX[DATA_W-1:0];
        if (v < DAT_MIN) return DAT_MIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    assign in_ready  = (state_q == IDLE) || (state_q == ACC);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DRAIN);
    assign out_hs    = out_valid & out_ready;
    assign out_last  = out_valid && (idx_q == IDX_LAST);
    assign out_data  = out_valid ? result : '0;
    assign out_idx   = idx_q;
    assign wt_addr   = k_q;
    assign done      = done_q;
    assign argmax    = argmax_q;

    // Product is clamped before the add; the first beat of a frame loads instead of accumulating.
    always_comb begin
        a_ext  = {{W_W{act_q[DATA_W-1]}}, act_q};
        w_lane = '0;
        w_ext  = '0;
        prod   = '0;
        psat   = '0;
        sum    = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_lane   = wt_data[j*W_W +: W_W];
            w_ext    = {{DATA_W{w_lane[W_W-1]}}, w_lane};
            prod     = a_ext * w_ext;
            psat     = sat_acc({{(SW-PW){prod[PW-1]}}, prod});
            sum      = {{(SW-ACC_W){acc_q[j][ACC_W-1]}}, acc_q[j]} + {{(SW-ACC_W){psat[ACC_W-1]}}, psat};
            acc_d[j] = acc_q[j];
            if (vld_q) acc_d[j] = first_q ? psat : sat_acc(sum);
        end
    end

    always_comb begin
        result = sat_data(acc_q[idx_q]);
`ifdef MLP_RELU_EN
        if (result[DATA_W-1]) result = '0;
`endif
        upd      = (idx_q == '0) || (result > best_q);
        cand_idx = upd ? idx_q : best_idx_q;
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        idx_d      = idx_q;
        act_d      = act_q;
        vld_d      = accept;
        first_d    = accept && (state_q == IDLE);
        best_d     = best_q;
        best_idx_d = best_idx_q;
        argmax_d   = argmax_q;
        done_d     = 1'b0;
        if (accept) act_d = in_data;
        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = FLUSH;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ACC;
                    end
                end
            end
            FLUSH: state_d = DRAIN;
            DRAIN: begin
                if (out_hs) begin
                    if (upd) begin
                        best_d     = result;
                        best_idx_d = idx_q;
                    end
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        argmax_d = cand_idx;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            idx_q      <= '0;
            act_q      <= '0;
            vld_q      <= 1'b0;
            first_q    <= 1'b0;
            best_q     <= '0;
            best_idx_q <= '0;
            argmax_q   <= '0;
            done_q     <= 1'b0;
            for (int j = 0; j < N_OUT; j++) acc_q[j] <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            idx_q      <= idx_d;
            act_q      <= act_d;
            vld_q      <= vld_d;
            first_q    <= first_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            argmax_q   <= argmax_d;
            done_q     <= done_d;
            for (int j = 0; j < N_OUT; j++) acc_q[j] <= acc_d[j];
        end
    end
endmodule

// File: tb/tb_mlp_layer_engine.sv
// Self-checking bench for mlp_layer_engine (N_IN=4, N_OUT=3, W_W=8, DATA_W=ACC_W=16) against a saturating-arithmetic model.
// The model honours MLP_RELU_EN so the same bench serves both builds.
module tb_mlp_layer_engine;
    localparam int N_IN = 4;
    localparam int N_OUT = 3;
    localparam int W_W = 8;
    localparam int DATA_W = 16;
    localparam int ACC_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [DATA_W-1:0] in_data = '0;
    logic [1:0] wt_addr;
    logic [N_OUT*W_W-1:0] wt_data = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic signed [DATA_W-1:0] out_data;
    logic [1:0] out_idx;
    logic out_last;
    logic done;
    logic [1:0] argmax;

    logic signed [DATA_W-1:0] actVec [N_IN];
    logic signed [W_W-1:0] wmem [N_IN][N_OUT];
    longint expRes [N_OUT];
    int expArg;
    int checks = 0;
    int errors = 0;

    mlp_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wt_addr(wt_addr), .wt_data(wt_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .done(done), .argmax(argmax)
    );

    always #5 clk = ~clk;

    // Synchronous weight memory: row for the address seen at an edge appears after that edge.
    always @(posedge clk) begin
        for (int j = 0; j < N_OUT; j++) wt_data[j*W_W +: W_W] <= wmem[wt_addr][j];
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint satv(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic computeExpected();
        longint acc, a, w, p;
        for (int j = 0; j < N_OUT; j++) begin
            acc = 0;
            for (int k = 0; k < N_IN; k++) begin
                a = actVec[k];
                w = wmem[k][j];
                p = satv(a * w);
                acc = (k == 0) ? p : satv(acc + p);
            end
`ifdef MLP_RELU_EN
            if (acc < 0) acc = 0;
`endif
            expRes[j] = acc;
        end
        expArg = 0;
        for (int j = 1; j < N_OUT; j++) if (expRes[j] > expRes[expArg]) expArg = j;
    endtask

    task automatic setWeights(input int w0, input int w1, input int w2);
        for (int k = 0; k < N_IN; k++) begin
            wmem[k][0] = W_W'(w0);
            wmem[k][1] = W_W'(w1);
            wmem[k][2] = W_W'(w2);
        end
    endtask

    task automatic setActs(input int a0, input int a1, input int a2, input int a3);
        actVec[0] = DATA_W'(a0);
        actVec[1] = DATA_W'(a1);
        actVec[2] = DATA_W'(a2);
        actVec[3] = DATA_W'(a3);
    endtask

    // gapMode: 0 continuous, 1 alternating valid, 2 random valid
    task automatic applyStimulus(input int startIdx, input int nBeats, input int gapMode);
        int i = startIdx;
        int cyc = 0;
        bit ph = 1'b0;
        while (i < nBeats && cyc < 200) begin
            @(negedge clk);
            cyc++;
            checkOutput("wt_addr", {30'd0, wt_addr}, i);
            in_valid = (gapMode == 0) ? 1'b1 : (gapMode == 1) ? !ph : 1'($urandom_range(0, 1));
            ph = !ph;
            in_data = actVec[i];
            if (in_valid && in_ready) i++;
        end
        if (i < nBeats) checkOutput("in_timeout", i, nBeats);
        @(negedge clk);
        in_valid = 1'b0;
        if (nBeats == N_IN) begin
            checkOutput("flush_in_ready", {31'd0, in_ready}, 0);
            checkOutput("flush_out_valid", {31'd0, out_valid}, 0);
        end
    endtask

    task automatic drainFrame(input int stallIdx, input int stallLen, input bit randReady, input bit chain);
        int nxt = 0;
        int cyc = 0;
        int stalled = 0;
        bit rdy;
        while (nxt < N_OUT && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) checkOutput("latency_out_valid", {31'd0, out_valid}, 1);
            if (out_valid) begin
                checkOutput("out_idx", {30'd0, out_idx}, nxt);
                checkOutput("out_data", out_data, 32'(expRes[nxt]));
                checkOutput("out_last", {31'd0, out_last}, (nxt == N_OUT - 1) ? 1 : 0);
                checkOutput("done_during_drain", {31'd0, done}, 0);
                if (randReady) rdy = ($urandom_range(0, 3) != 0);
                else if (nxt == stallIdx && stalled < stallLen) begin
                    rdy = 1'b0;
                    stalled++;
                end else rdy = 1'b1;
                out_ready = rdy;
                if (rdy) nxt++;
            end else out_ready = 1'b0;
        end
        if (nxt < N_OUT) checkOutput("out_timeout", nxt, N_OUT);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("done_pulse", {31'd0, done}, 1);
        checkOutput("argmax", {30'd0, argmax}, expArg);
        checkOutput("done_in_ready", {31'd0, in_ready}, 1);
        checkOutput("done_out_valid", {31'd0, out_valid}, 0);
        if (chain) begin
            in_valid = 1'b1;
            in_data = actVec[0];
        end else begin
            @(negedge clk);
            checkOutput("done_cleared", {31'd0, done}, 0);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 1);
        checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 0);
        checkOutput({tag, "_out_last"}, {31'd0, out_last}, 0);
        checkOutput({tag, "_done"}, {31'd0, done}, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
        checkOutput({tag, "_out_idx"}, {30'd0, out_idx}, 0);
        checkOutput({tag, "_argmax"}, {30'd0, argmax}, 0);
        checkOutput({tag, "_wt_addr"}, {30'd0, wt_addr}, 0);
    endtask

    initial begin
        setActs(0, 0, 0, 0);
        setWeights(0, 0, 0);
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;

        $display("[TB] basic frame");
        setActs(1, 2, 3, 4);
        setWeights(1, -1, 2);
        computeExpected();
        applyStimulus(0, N_IN, 0);
        drainFrame(-1, 0, 1'b0, 1'b0);

        $display("[TB] alternating in_valid");
        applyStimulus(0, N_IN, 1);
        drainFrame(-1, 0, 1'b0, 1'b0);

        $display("[TB] out_ready stall at idx 1");
        applyStimulus(0, N_IN, 0);
        drainFrame(1, 3, 1'b0, 1'b0);

        $display("[TB] positive and negative saturation");
        setActs(32767, 32767, 32767, 32767);
        setWeights(127, 127, 127);
        computeExpected();
        applyStimulus(0, N_IN, 0);
        drainFrame(-1, 0, 1'b0, 1'b0);
        setWeights(-128, -128, -128);
        computeExpected();
        applyStimulus(0, N_IN, 0);
        drainFrame(-1, 0, 1'b0, 1'b0);

        $display("[TB] argmax tie");
        setActs(1, 1, 1, 2);
        setWeights(1, 1, 1);
        wmem[3][2] = 8'sd0;
        computeExpected();
        applyStimulus(0, N_IN, 0);
        drainFrame(-1, 0, 1'b0, 1'b0);

        $display("[TB] back-to-back frames");
        setActs(1, 2, 3, 4);
        setWeights(1, -1, 2);
        computeExpected();
        applyStimulus(0, N_IN, 0);
        setActs(2, 2, 2, 2);
        drainFrame(-1, 0, 1'b0, 1'b1);
        computeExpected();
        applyStimulus(1, N_IN, 0);
        drainFrame(-1, 0, 1'b0, 1'b0);

        $display("[TB] reset mid-frame");
        setActs(5, 6, 7, 8);
        applyStimulus(0, 3, 0);
        reset = 1'b1;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        reset = 1'b0;
        setActs(3, -1, 4, 1);
        computeExpected();
        applyStimulus(0, N_IN, 0);
        drainFrame(-1, 0, 1'b0, 1'b0);

        $display("[TB] randomized frames");
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < N_IN; k++) begin
                actVec[k] = (f < 4) ? DATA_W'($urandom_range(0, 600)) - 16'sd300 : DATA_W'($urandom);
                for (int j = 0; j < N_OUT; j++) wmem[k][j] = W_W'($urandom);
            end
            computeExpected();
            applyStimulus(0, N_IN, 2);
            drainFrame(-1, 0, 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
